// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   REG_IDX_W            register index width of the core
//   MEM_WAIT_CYCLES_DEF  default number of cycles a memory access holds the pipe
//   PERF_W_DEF           default performance counter width
//   WAIT_CNT_W           width of the memory-wait down-counter (covers 1..15)
//   pipe_state_e         sequencer FSM state, 2-bit encoding
//   reg_match()          destination/source compare qualified by write-back
package pipe_ctrl_pkg;

    localparam int REG_IDX_W           = 4;
    localparam int MEM_WAIT_CYCLES_DEF = 5;
    localparam int PERF_W_DEF          = 16;
    localparam int WAIT_CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_MEM_WAIT    = 2'd1,
        ST_MEM_RELEASE = 2'd2
    } pipe_state_e;

    // True when a later-stage instruction will write the register being read.
    function automatic logic reg_match(
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dest,
        input logic                 wb_en
    );
        return wb_en && (src == dest);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// RAW hazard detector between the ID instruction and the EXE/MEM destinations.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the hazard flag is consumed by the sequencer's priority mux.
//
// Ports:
//   id_src1, id_src2, id_two_src    source registers of the ID instruction
//   exe_dest, exe_wb_en, exe_mem_r_en  EXE destination, write-back, load flag
//   mem_dest, mem_wb_en             MEM destination and write-back
//   fwd_en                          forwarding unit resolves non-load hazards
//   hazard                          ID instruction must wait one cycle
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 fwd_en,
    output logic                 hazard
);

    logic m1;
    logic m2;
    logic n1;
    logic n2;

    always_comb begin
        m1 = reg_match(id_src1, exe_dest, exe_wb_en);
        m2 = id_two_src && reg_match(id_src2, exe_dest, exe_wb_en);
        n1 = reg_match(id_src1, mem_dest, mem_wb_en);
        n2 = id_two_src && reg_match(id_src2, mem_dest, mem_wb_en);
    end

    // With forwarding, only a load in EXE is too late to forward from;
    // every other dependency is bypassed.
    always_comb begin
        hazard = 1'b0;
        if (fwd_en) begin
            hazard = exe_mem_r_en && (m1 || m2);
        end else begin
            hazard = m1 || m2 || n1 || n2;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: freeze/flush controls for every stage register of the core.
// Latency: control outputs are combinational from inputs and the current FSM state.
// Backpressure: a memory access freezes the whole pipe for MEM_WAIT_CYCLES cycles,
//               then releases it for one cycle so the access can retire.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-low reset
//   id_*, exe_*, mem_*, fwd_en hazard-detection inputs (see hazard_detect)
//   exe_branch_taken          branch in EXE resolved taken
//   mem_access                MEM stage holds a load or store
//   freeze_front              hold PC and IF/ID
//   id_bubble                 flush the ID/EXE register (insert NOP)
//   flush_if                  clear IF/ID
//   mem_freeze                hold every pipeline register and PC
//   busy_state                current FSM state, debug only
//   stall_cnt, flush_cnt      saturating performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF,
    parameter int PERF_W          = PERF_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 fwd_en,
    input  logic                 exe_branch_taken,
    input  logic                 mem_access,
    output logic                 freeze_front,
    output logic                 id_bubble,
    output logic                 flush_if,
    output logic                 mem_freeze,
    output logic [1:0]           busy_state,
    output logic [PERF_W-1:0]    stall_cnt,
    output logic [PERF_W-1:0]    flush_cnt
);

    if (MEM_WAIT_CYCLES < 1 || MEM_WAIT_CYCLES > 15) begin : g_bad_wait
        $error("pipe_ctrl: MEM_WAIT_CYCLES must be in 1..15");
    end

    // The RUN cycle that first sees mem_access is already frozen, so the
    // WAIT state only needs to cover the remaining MEM_WAIT_CYCLES-1 cycles.
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(MEM_WAIT_CYCLES - 1);

    pipe_state_e           state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  hazard;

    hazard_detect u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .fwd_en       (fwd_en),
        .hazard       (hazard)
    );

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_access) begin
                        if (MEM_WAIT_CYCLES == 1) begin
                            state    <= ST_MEM_RELEASE;
                            wait_cnt <= '0;
                        end else begin
                            state    <= ST_MEM_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    // Leave when the counter is about to reach zero so the
                    // WAIT state lasts exactly WAIT_INIT cycles.
                    if (wait_cnt <= WAIT_CNT_W'(1)) begin
                        state    <= ST_MEM_RELEASE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                    end
                end
                ST_MEM_RELEASE: begin
                    // mem_access is deliberately ignored here: this is the
                    // cycle in which the finished access advances out of MEM.
                    state <= ST_RUN;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign busy_state = state;

    // Mealy: the first RUN cycle that sees mem_access is already frozen.
    always_comb begin
        mem_freeze = 1'b0;
        if (rst) begin
            mem_freeze = (state == ST_MEM_WAIT) ||
                         ((state == ST_RUN) && mem_access);
        end
    end

    // ------------------------------------------------------------------
    // Front-end priority mux
    // ------------------------------------------------------------------
    // A frozen pipe overrides everything: a taken branch held in EXE keeps
    // exe_branch_taken asserted and is acted on in the first unfrozen cycle.
    always_comb begin
        freeze_front = 1'b0;
        id_bubble    = 1'b0;
        flush_if     = 1'b0;
        if (rst && !mem_freeze) begin
            if (exe_branch_taken) begin
                flush_if  = 1'b1;
                id_bubble = 1'b1;
            end else if (hazard) begin
                freeze_front = 1'b1;
                id_bubble    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = freeze_front || mem_freeze;
    assign flush_inc = flush_if;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {PERF_W{1'b1}})) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (flush_inc && (flush_cnt != {PERF_W{1'b1}})) begin
                flush_cnt <= flush_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default build (A) and a MEM_WAIT_CYCLES=1,
// PERF_W=4 build (B) driven by the same inputs.
// Inputs change 1 time unit after posedge; outputs are sampled 2 units after.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en;
    logic       exe_branch_taken, mem_access;

    logic        a_ff, a_bub, a_fl, a_mf;
    logic [1:0]  a_st;
    logic [15:0] a_stall, a_flush;
    logic        b_ff, b_bub, b_fl, b_mf;
    logic [1:0]  b_st;
    logic [3:0]  b_stall, b_flush;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl u_dut_a (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
        .exe_branch_taken(exe_branch_taken), .mem_access(mem_access),
        .freeze_front(a_ff), .id_bubble(a_bub), .flush_if(a_fl),
        .mem_freeze(a_mf), .busy_state(a_st),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipe_ctrl #(.MEM_WAIT_CYCLES(1), .PERF_W(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
        .exe_branch_taken(exe_branch_taken), .mem_access(mem_access),
        .freeze_front(b_ff), .id_bubble(b_bub), .flush_if(b_fl),
        .mem_freeze(b_mf), .busy_state(b_st),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; leave the bench 1 unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; fwd_en = 1'b0;
        exe_branch_taken = 1'b0; mem_access = 1'b0;
    endtask

    task automatic set_exe_hazard();
        fwd_en = 1'b0; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        mem_access = 1'b1;
        exe_branch_taken = 1'b1;

        // ---- reset with active inputs ----
        tick(2);
        #1;
        check("rst_mem_freeze", a_mf, 0);
        check("rst_flush_if", a_fl, 0);
        check("rst_id_bubble", a_bub, 0);
        check("rst_freeze_front", a_ff, 0);
        check("rst_busy_state", a_st, 0);
        check("rst_stall_cnt", a_stall, 0);
        check("rst_flush_cnt", a_flush, 0);
        check("rst_b_mem_freeze", b_mf, 0);

        rst = 1'b1;
        clear_inputs();
        #1;
        check("idle_freeze_front", a_ff, 0);
        check("idle_mem_freeze", a_mf, 0);
        tick();
        check("idle_stall_cnt", a_stall, 0);

        // ---- EXE RAW hazard without forwarding ----
        set_exe_hazard();
        #1;
        check("raw_exe_freeze_front", a_ff, 1);
        check("raw_exe_id_bubble", a_bub, 1);
        check("raw_exe_flush_if", a_fl, 0);
        tick();
        check("raw_exe_stall_cnt", a_stall, 1);

        // Same dependency is forwarded when the producer is not a load.
        fwd_en = 1'b1;
        #1;
        check("fwd_alu_freeze_front", a_ff, 0);
        check("fwd_alu_id_bubble", a_bub, 0);
        tick();
        check("fwd_alu_stall_cnt", a_stall, 1);

        // ---- MEM RAW hazard without forwarding ----
        clear_inputs();
        id_src1 = 4'd3; mem_dest = 4'd3; mem_wb_en = 1'b1;
        #1;
        check("raw_mem_freeze_front", a_ff, 1);
        tick();
        check("raw_mem_stall_cnt", a_stall, 2);

        // id_src2 match does not count when id_two_src=0.
        id_src1 = 4'd0; id_src2 = 4'd3; id_two_src = 1'b0;
        #1;
        check("src2_unused_freeze_front", a_ff, 0);
        tick();

        // ---- load-use hazard on src2 with forwarding ----
        clear_inputs();
        fwd_en = 1'b1; exe_mem_r_en = 1'b1; id_two_src = 1'b1;
        id_src2 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1;
        #1;
        check("load_use_freeze_front", a_ff, 1);
        check("load_use_id_bubble", a_bub, 1);
        tick();
        check("load_use_stall_cnt", a_stall, 3);
        exe_mem_r_en = 1'b0;
        #1;
        check("load_use_gone", a_ff, 0);

        // ---- memory wait: A freezes 5 cycles then releases; B alternates ----
        clear_inputs();
        mem_access = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("mw_freeze_%0d", i), a_mf, (i < 5) ? 1 : 0);
            check($sformatf("mw_state_%0d", i), a_st, (i == 0) ? 0 : ((i < 5) ? 1 : 2));
            check($sformatf("mw1_freeze_%0d", i), b_mf, (i % 2 == 0) ? 1 : 0);
            check($sformatf("mw1_state_%0d", i), b_st, (i % 2 == 0) ? 0 : 2);
            tick();
        end
        mem_access = 1'b0;
        #1;
        check("mw_done_state", a_st, 0);
        check("mw_done_freeze", a_mf, 0);
        check("mw_stall_cnt", a_stall, 8);
        check("mw1_stall_cnt", b_stall, 6);
        tick();

        // ---- taken branch + hazard held while frozen ----
        mem_access = 1'b1;
        exe_branch_taken = 1'b1;
        set_exe_hazard();
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("br_flush_if_%0d", i), a_fl, (i == 5) ? 1 : 0);
            check($sformatf("br_id_bubble_%0d", i), a_bub, (i == 5) ? 1 : 0);
            check($sformatf("br_freeze_front_%0d", i), a_ff, 0);
            tick();
        end
        clear_inputs();
        #1;
        check("br_flush_cnt", a_flush, 1);
        check("br_stall_cnt", a_stall, 13);
        check("br1_flush_cnt", b_flush, 3);
        check("br1_stall_cnt", b_stall, 9);

        // ---- continuous hazard: B's 4-bit counter saturates at 15 ----
        set_exe_hazard();
        tick(10);
        #1;
        check("sat_b_freeze_front", b_ff, 1);
        check("sat_b_stall_cnt", b_stall, 15);
        check("sat_a_stall_cnt", a_stall, 23);

        // ---- branch beats hazard when not frozen ----
        exe_branch_taken = 1'b1;
        #1;
        check("br_only_flush_if", a_fl, 1);
        check("br_only_id_bubble", a_bub, 1);
        check("br_only_freeze_front", a_ff, 0);
        tick();
        check("br_only_flush_cnt", a_flush, 2);
        check("br_only_stall_cnt", a_stall, 23);

        // ---- reset in the middle of a wait restarts a full wait ----
        clear_inputs();
        mem_access = 1'b1;
        tick(3);
        #1;
        check("mid_state_wait", a_st, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_forced_freeze", a_mf, 0);
        tick();
        check("mid_rst_state", a_st, 0);
        check("mid_rst_stall_cnt", a_stall, 0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("re_freeze_%0d", i), a_mf, (i < 5) ? 1 : 0);
            tick();
        end
        mem_access = 1'b0;
        #1;
        check("re_stall_cnt", a_stall, 5);
        check("re_state", a_st, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
